cpu_program_loader: RTL and testbench

//  Upstream feeder for the pipelined RISC-V cpu top. Accepts a 32-bit valid/ready word stream
//  and writes it into instruction memory through addr_ext/wen_ext/wdata_ext. It then writes

---
 rtl/loader_pkg.sv | 24 ++
 rtl/loader_beat_counter.sv | 24 ++
 rtl/cpu_program_loader.sv | 156 +++++++++++++++
 tb/tb_cpu_program_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the cpu program loader: FSM encoding,
// header field placement and per-memory address shifts.
package loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_I_HDR,
    S_I_LOAD,
    S_D_HDR,
    S_D_LO,
    S_D_HI,
    S_R_HDR,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  // Header beats carry their count in the low bits of the stream word.
  localparam int HDR_CNT_LSB = 0;

  localparam int IMEM_SHIFT = 2;
  localparam int DMEM_SHIFT = 3;

endpackage

// File: rtl/loader_beat_counter.sv
// Loadable down-counter; saturates at zero and flags zero / one-remaining.
module loader_beat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (srst)                count <= '0;
    else if (load)           count <= load_val;
    else if (dec && !zero)   count <= count - 1'b1;
  end

  assign zero = (count == '0);
  assign last = (count == W'(1));

endmodule

// File: rtl/cpu_program_loader.sv
// Streams a program image into cpu imem/dmem, then runs the cpu for a
// programmed number of cycles. The cpu stays disabled for the whole load.
module cpu_program_loader
  import loader_pkg::*;
#(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        enable,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t state, state_nx;

  logic [CNT_W-1:0] hdr;
  logic [CNT_W-1:0] idx;
  logic [31:0]      lo_half;
  logic             fire, i_fire, lo_fire, hi_fire;
  logic             wc_load, wc_dec, wc_zero, wc_last;
  logic             rc_load, rc_dec, rc_zero, rc_last;
  logic [CNT_W-1:0] wc_count, rc_count;

  assign hdr     = s_data[HDR_CNT_LSB +: CNT_W];
  assign fire    = s_valid & s_ready;
  assign i_fire  = fire && (state == S_I_LOAD);
  assign lo_fire = fire && (state == S_D_LO);
  assign hi_fire = fire && (state == S_D_HI);

  assign wc_load = fire && ((state == S_I_HDR) || (state == S_D_HDR));
  assign wc_dec  = i_fire | hi_fire;
  assign rc_load = fire && (state == S_R_HDR);
  assign rc_dec  = (state == S_RUN);

  loader_beat_counter #(.W(CNT_W)) u_word_cnt (
    .clk      (clk),
    .srst     (srst),
    .load     (wc_load),
    .load_val (hdr),
    .dec      (wc_dec),
    .count    (wc_count),
    .zero     (wc_zero),
    .last     (wc_last)
  );

  loader_beat_counter #(.W(CNT_W)) u_run_cnt (
    .clk      (clk),
    .srst     (srst),
    .load     (rc_load),
    .load_val (hdr),
    .dec      (rc_dec),
    .count    (rc_count),
    .zero     (rc_zero),
    .last     (rc_last)
  );

  always_ff @(posedge clk) begin
    if (srst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (s_valid) state_nx = S_I_HDR;
      S_I_HDR:  if (fire) begin
                  if (hdr > CNT_W'(IMEM_WORDS)) state_nx = S_ERR;
                  else if (hdr == '0)           state_nx = S_D_HDR;
                  else                          state_nx = S_I_LOAD;
                end
      S_I_LOAD: if (fire && (wc_last || wc_zero)) state_nx = S_D_HDR;
      S_D_HDR:  if (fire) begin
                  if (hdr > CNT_W'(DMEM_WORDS)) state_nx = S_ERR;
                  else if (hdr == '0)           state_nx = S_R_HDR;
                  else                          state_nx = S_D_LO;
                end
      S_D_LO:   if (fire) state_nx = S_D_HI;
      S_D_HI:   if (fire) state_nx = (wc_last || wc_zero) ? S_R_HDR : S_D_LO;
      S_R_HDR:  if (fire) state_nx = S_RUN;
      // A zero cycle budget never reaches last, so the cpu runs until srst.
      S_RUN:    if (!rc_zero && rc_last) state_nx = S_DONE;
      S_DONE:   state_nx = S_DONE;
      S_ERR:    state_nx = S_ERR;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    err     = 1'b0;
    enable  = 1'b0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_I_HDR, S_I_LOAD, S_D_HDR, S_D_LO, S_D_HI, S_R_HDR: s_ready = 1'b1;
      S_RUN:   enable = 1'b1;
      S_DONE:  begin busy = 1'b0; done = 1'b1; end
      S_ERR:   begin busy = 1'b0; err  = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  // One index serves both phases; it restarts at each count header.
  always_ff @(posedge clk) begin
    if (srst)                   idx <= '0;
    else if (wc_load)           idx <= '0;
    else if (i_fire || hi_fire) idx <= idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst)         lo_half <= '0;
    else if (lo_fire) lo_half <= s_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wen_ext     <= 1'b0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      wen_ext_2   <= 1'b0;
      addr_ext_2  <= '0;
      wdata_ext_2 <= '0;
    end else begin
      wen_ext   <= i_fire;
      wen_ext_2 <= hi_fire;
      if (i_fire) begin
        addr_ext  <= 64'(idx) << IMEM_SHIFT;
        wdata_ext <= s_data;
      end
      if (hi_fire) begin
        addr_ext_2  <= 64'(idx) << DMEM_SHIFT;
        wdata_ext_2 <= {s_data, lo_half};
      end
    end
  end

  assign ren_ext   = 1'b0;
  assign ren_ext_2 = 1'b0;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed bench for cpu_program_loader: table of whole-stream scenarios
// plus hand-written reset and mid-load reset sequences.
module tb_cpu_program_loader;

  logic        clk = 1'b0;
  logic        srst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic        enable;
  logic        busy;
  logic        done;
  logic        err;

  cpu_program_loader dut (
    .clk         (clk),
    .srst        (srst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .enable      (enable),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    int          c;
  } wr_t;

  wr_t ilog[$];
  wr_t dlog[$];
  int  en_cnt;
  int  ovl;

  // Observe the memory-side interface away from the clock edge.
  always @(negedge clk) begin
    if (!srst) begin
      if (wen_ext)   ilog.push_back('{addr_ext, {32'h0, wdata_ext}, cyc});
      if (wen_ext_2) dlog.push_back('{addr_ext_2, wdata_ext_2, cyc});
      if (enable) en_cnt++;
      if (enable && (wen_ext || wen_ext_2)) ovl++;
    end
  end

  typedef struct {
    int ni;
    int nd;
    int nc;
    bit gaps;
    bit exp_err;
    bit forever_run;
  } scen_t;

  scen_t       tbl[7];
  logic [31:0] prog[3];
  logic [31:0] dpat[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 0);
    chk({tag, "_wen"}, 64'(wen_ext), 0);
    chk({tag, "_wen2"}, 64'(wen_ext_2), 0);
    chk({tag, "_ren"}, 64'(ren_ext | ren_ext_2), 0);
    chk({tag, "_addr"}, addr_ext, 0);
    chk({tag, "_addr2"}, addr_ext_2, 0);
    chk({tag, "_wdata"}, 64'(wdata_ext), 0);
    chk({tag, "_wdata2"}, wdata_ext_2, 0);
    chk({tag, "_enable"}, 64'(enable), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_err"}, 64'(err), 0);
  endtask

  task automatic do_reset();
    srst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    srst = 1'b0;
    ilog.delete();
    dlog.delete();
    en_cnt = 0;
    ovl = 0;
  endtask

  // Present one beat and return 1 time unit after the edge that accepted it.
  task automatic send(input logic [31:0] d, input bit gaps);
    int w;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b1;
    s_data = d;
    w = 0;
    @(negedge clk);
    while (!s_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) begin
      total_cnt++;
      $display("FAIL send_timeout beat=%h s_ready never rose", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_reached", 64'(done), 1);
  endtask

  function automatic logic [31:0] word_i(input int s, input int k);
    if (s == 0) return prog[k];
    return 32'h5A00_0000 ^ (32'(s) << 20) ^ 32'(k);
  endfunction

  function automatic logic [31:0] beat_d(input int s, input int b);
    if (s == 1) return dpat[b];
    return 32'hD000_0000 ^ (32'(s) << 20) ^ 32'(b);
  endfunction

  task automatic run_scenario(input int s);
    scen_t sc;
    sc = tbl[s];
    do_reset();
    send(32'(sc.ni), sc.gaps);
    if (sc.ni > 512) begin
      chk($sformatf("s%0d_err_after_ni", s), 64'(err), 1);
      chk($sformatf("s%0d_ready_in_err", s), 64'(s_ready), 0);
      chk($sformatf("s%0d_busy_in_err", s), 64'(busy), 0);
    end else begin
      for (int k = 0; k < sc.ni; k++) send(word_i(s, k), sc.gaps);
      send(32'(sc.nd), sc.gaps);
      if (sc.nd > 1024) begin
        chk($sformatf("s%0d_err_after_nd", s), 64'(err), 1);
        chk($sformatf("s%0d_ready_in_err", s), 64'(s_ready), 0);
      end else begin
        for (int b = 0; b < 2 * sc.nd; b++) send(beat_d(s, b), sc.gaps);
        send(32'(sc.nc), sc.gaps);
        s_valid = 1'b0;
        chk($sformatf("s%0d_enable_rise", s), 64'(enable), 1);
        chk($sformatf("s%0d_busy_run", s), 64'(busy), 1);
      end
    end

    if (sc.exp_err) begin
      s_valid = 1'b1;
      s_data = 32'hFFFF_FFFF;
      repeat (5) @(posedge clk);
      #1;
      s_valid = 1'b0;
      chk($sformatf("s%0d_err_sticky", s), 64'(err), 1);
      chk($sformatf("s%0d_err_no_enable", s), 64'(en_cnt), 0);
      chk($sformatf("s%0d_err_no_wen", s), 64'(ilog.size() + dlog.size()), 0);
      return;
    end

    if (sc.forever_run) begin
      repeat (40) @(posedge clk);
      #1;
      chk($sformatf("s%0d_forever_enable", s), 64'(enable), 1);
      chk($sformatf("s%0d_forever_done", s), 64'(done), 0);
      chk($sformatf("s%0d_forever_busy", s), 64'(busy), 1);
      do_reset();
      return;
    end

    wait_done();
    chk($sformatf("s%0d_enable_cycles", s), 64'(en_cnt), 64'(sc.nc));
    chk($sformatf("s%0d_enable_off", s), 64'(enable), 0);
    chk($sformatf("s%0d_done_busy", s), 64'(busy), 0);
    chk($sformatf("s%0d_no_overlap", s), 64'(ovl), 0);
    chk($sformatf("s%0d_imem_count", s), 64'(ilog.size()), 64'(sc.ni));
    chk($sformatf("s%0d_dmem_count", s), 64'(dlog.size()), 64'(sc.nd));
    for (int k = 0; k < sc.ni && k < ilog.size(); k++) begin
      chk($sformatf("s%0d_iaddr%0d", s, k), ilog[k].addr, 64'(4 * k));
      chk($sformatf("s%0d_idata%0d", s, k), ilog[k].data, {32'h0, word_i(s, k)});
      if (!sc.gaps && k > 0)
        chk($sformatf("s%0d_ispacing%0d", s, k), 64'(ilog[k].c - ilog[k-1].c), 1);
    end
    for (int j = 0; j < sc.nd && j < dlog.size(); j++) begin
      chk($sformatf("s%0d_daddr%0d", s, j), dlog[j].addr, 64'(8 * j));
      chk($sformatf("s%0d_ddata%0d", s, j), dlog[j].data,
          {beat_d(s, 2 * j + 1), beat_d(s, 2 * j)});
      if (!sc.gaps && j > 0)
        chk($sformatf("s%0d_dspacing%0d", s, j), 64'(dlog[j].c - dlog[j-1].c), 2);
    end
  endtask

  initial begin
    prog = '{32'h0050_0093, 32'h0060_0113, 32'h0020_81B3};
    dpat = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    //        ni    nd    nc  gaps err forever
    tbl[0] = '{3,    0,    10, 0,   0,  0};
    tbl[1] = '{1,    2,    3,  0,   0,  0};
    tbl[2] = '{16,   3,    2,  1,   0,  0};
    tbl[3] = '{513,  0,    0,  0,   1,  0};
    tbl[4] = '{0,    0,    0,  0,   0,  1};
    tbl[5] = '{0,    1025, 0,  0,   1,  0};
    tbl[6] = '{512,  1024, 1,  0,   0,  0};

    srst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    en_cnt = 0;
    ovl = 0;

    do_reset();
    for (int s = 0; s < 7; s++) run_scenario(s);

    // srst while word 5 of an 8-word image is on the bus.
    do_reset();
    send(32'd8, 1'b0);
    for (int k = 0; k < 5; k++) send(32'hC0DE_0000 + 32'(k), 1'b0);
    chk("pre_srst_wen", 64'(wen_ext), 1);
    chk("pre_srst_addr", addr_ext, 64'd16);
    s_data = 32'hC0DE_0005;
    srst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("mid_srst");
    srst = 1'b0;
    s_valid = 1'b0;
    ilog.delete();
    dlog.delete();
    en_cnt = 0;
    ovl = 0;
    send(32'd2, 1'b0);
    send(32'hAAAA_0001, 1'b0);
    send(32'hAAAA_0002, 1'b0);
    send(32'd0, 1'b0);
    send(32'd1, 1'b0);
    s_valid = 1'b0;
    wait_done();
    chk("reload_count", 64'(ilog.size()), 2);
    if (ilog.size() == 2) begin
      chk("reload_addr0", ilog[0].addr, 64'd0);
      chk("reload_data0", ilog[0].data, 64'h0000_0000_AAAA_0001);
      chk("reload_addr1", ilog[1].addr, 64'd4);
      chk("reload_data1", ilog[1].data, 64'h0000_0000_AAAA_0002);
    end
    chk("reload_enable_cycles", 64'(en_cnt), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
